// File: rtl/gc_cntr_rx.sv
// Receive side of a Gray-coded counter crossing: synchronizes the remote count,
// decodes it to binary, reports signed steps and keeps a local running total.
module gc_cntr_rx #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ACC_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     gc_in,
    input  logic                 clear,
    output logic [WIDTH-1:0]     bin_out,
    output logic [WIDTH-1:0]     delta,
    output logic                 adv,
    output logic                 multi,
    output logic [ACC_WIDTH-1:0] acc,
    output logic                 aligned
);

    localparam int CNT_W = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] ALIGN_LAST = CNT_W'(SYNC_STAGES);

    typedef enum logic {
        ALIGN,
        TRACK
    } state_e;

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]       s_gc;
    logic [WIDTH-1:0]       bin_dec;
    logic [WIDTH-1:0]       gc_diff;
    logic [WIDTH-1:0]       step;

    logic [CNT_W-1:0]       align_cnt_q, align_cnt_d;
    logic [WIDTH-1:0]       prev_gc_q, prev_gc_d;
    logic [WIDTH-1:0]       bin_q, bin_d;
    logic [WIDTH-1:0]       delta_q, delta_d;
    logic                   adv_q, adv_d;
    logic                   multi_q, multi_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic                   aligned_q, aligned_d;

    // Plain flop chain: nothing may sit between stages or the MTBF suffers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= gc_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s_gc = sync_q[SYNC_STAGES-1];

    always_comb begin
        bin_dec = '0;
        for (int i = 0; i < WIDTH; i++) bin_dec[i] = ^(s_gc >> i);
    end

    assign gc_diff = s_gc ^ prev_gc_q;
    assign step    = bin_dec - bin_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ALIGN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ALIGN;
        end else begin
            case (state_q)
                ALIGN:   if (align_cnt_q == ALIGN_LAST) state_d = TRACK;
                TRACK:   state_d = TRACK;
                default: state_d = ALIGN;
            endcase
        end
    end

    // The ALIGN wait lets stale synchronizer contents flush before the first sample is taken.
    always_comb begin
        align_cnt_d = align_cnt_q;
        prev_gc_d   = prev_gc_q;
        bin_d       = bin_q;
        delta_d     = delta_q;
        adv_d       = 1'b0;
        multi_d     = 1'b0;
        acc_d       = acc_q;
        aligned_d   = aligned_q;
        if (clear) begin
            align_cnt_d = '0;
            aligned_d   = 1'b0;
        end else if (state_q == ALIGN) begin
            if (align_cnt_q == ALIGN_LAST) begin
                align_cnt_d = '0;
                prev_gc_d   = s_gc;
                bin_d       = bin_dec;
                acc_d       = '0;
                aligned_d   = 1'b1;
            end else begin
                align_cnt_d = align_cnt_q + 1'b1;
            end
        end else if (gc_diff != '0) begin
            prev_gc_d = s_gc;
            bin_d     = bin_dec;
            delta_d   = step;
            adv_d     = 1'b1;
            multi_d   = (gc_diff & (gc_diff - 1'b1)) != '0;
            acc_d     = acc_q + ACC_WIDTH'($signed(step));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            align_cnt_q <= '0;
            prev_gc_q   <= '0;
            bin_q       <= '0;
            delta_q     <= '0;
            adv_q       <= 1'b0;
            multi_q     <= 1'b0;
            acc_q       <= '0;
            aligned_q   <= 1'b0;
        end else begin
            align_cnt_q <= align_cnt_d;
            prev_gc_q   <= prev_gc_d;
            bin_q       <= bin_d;
            delta_q     <= delta_d;
            adv_q       <= adv_d;
            multi_q     <= multi_d;
            acc_q       <= acc_d;
            aligned_q   <= aligned_d;
        end
    end

    assign bin_out = bin_q;
    assign delta   = delta_q;
    assign adv     = adv_q;
    assign multi   = multi_q;
    assign acc     = acc_q;
    assign aligned = aligned_q;

endmodule

// File: tb/tb_gc_cntr_rx.sv
// Bench for gc_cntr_rx: directed scenarios followed by random Gray traffic,
// every cycle compared against an arithmetic reference model.
module tb_gc_cntr_rx;

    localparam int W  = 8;
    localparam int SS = 2;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic [W-1:0]  gc_in = '0;
    logic [W-1:0]  bin_out, delta;
    logic          adv, multi, aligned;
    logic [AW-1:0] acc;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [W-1:0]  hist [$];
    bit            mTrack = 0;
    int            mCnt = 0;
    logic [W-1:0]  mPrevGc = '0, mBin = '0, mDelta = '0;
    logic          mAdv = 0, mMulti = 0, mAligned = 0;
    logic [AW-1:0] mAcc = '0;
    int            curBin = 0;

    always #5 clk = ~clk;

    gc_cntr_rx #(.WIDTH(W), .SYNC_STAGES(SS), .ACC_WIDTH(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .gc_in   (gc_in),
        .clear   (clear),
        .bin_out (bin_out),
        .delta   (delta),
        .adv     (adv),
        .multi   (multi),
        .acc     (acc),
        .aligned (aligned)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] grayToBin(input logic [W-1:0] g);
        logic [W-1:0] r;
        r = g;
        for (int s = 1; s < W; s = s * 2) r = r ^ (r >> s);
        return r;
    endfunction

    function automatic logic [W-1:0] binToGray(input int b);
        logic [W-1:0] v;
        v = W'(b);
        return v ^ (v >> 1);
    endfunction

    // Samples reach the decoder SS edges after they are taken; hist models that delay.
    task automatic modelEdge();
        logic [W-1:0] s, nb;
        int stepVal;
        if (rst) begin
            hist.delete();
            repeat (SS) hist.push_back('0);
            mTrack = 0; mCnt = 0; mPrevGc = '0; mBin = '0; mDelta = '0;
            mAdv = 0; mMulti = 0; mAcc = '0; mAligned = 0;
            return;
        end
        s = hist[0];
        mAdv = 0;
        mMulti = 0;
        if (clear) begin
            mTrack = 0; mCnt = 0; mAligned = 0;
        end else if (!mTrack) begin
            if (mCnt == SS) begin
                mTrack = 1; mAligned = 1; mCnt = 0;
                mPrevGc = s; mBin = grayToBin(s); mAcc = '0;
            end else begin
                mCnt++;
            end
        end else if (s != mPrevGc) begin
            nb = grayToBin(s);
            stepVal = int'(nb) - int'(mBin);
            if (stepVal >= (1 << (W-1))) stepVal -= (1 << W);
            if (stepVal < -(1 << (W-1))) stepVal += (1 << W);
            mDelta  = W'(stepVal);
            mAdv    = 1;
            mMulti  = ($countones(s ^ mPrevGc) > 1);
            mAcc    = AW'(int'(mAcc) + stepVal);
            mBin    = nb;
            mPrevGc = s;
        end
        void'(hist.pop_front());
        hist.push_back(gc_in);
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("bin_out", 32'(bin_out), 32'(mBin));
        checkOutput("delta",   32'(delta),   32'(mDelta));
        checkOutput("adv",     32'(adv),     32'(mAdv));
        checkOutput("multi",   32'(multi),   32'(mMulti));
        checkOutput("acc",     32'(acc),     32'(mAcc));
        checkOutput("aligned", 32'(aligned), 32'(mAligned));
    endtask

    task automatic applyStimulus(input logic [W-1:0] g, input logic c, input logic r, input int n);
        gc_in = g;
        clear = c;
        rst   = r;
        repeat (n) tick();
    endtask

    initial begin
        logic [W-1:0] incSeq [4];
        incSeq = '{8'h01, 8'h03, 8'h02, 8'h06};

        applyStimulus(8'h00, 1'b0, 1'b1, 2);
        checkOutput("rst_aligned", 32'(aligned), 32'd0);
        applyStimulus(8'h00, 1'b0, 1'b0, 2);
        checkOutput("aligned_early", 32'(aligned), 32'd0);
        tick();
        checkOutput("aligned_on_time", 32'(aligned), 32'd1);

        foreach (incSeq[i]) applyStimulus(incSeq[i], 1'b0, 1'b0, 4);
        checkOutput("inc_bin", 32'(bin_out), 32'd4);
        checkOutput("inc_acc", 32'(acc), 32'd4);

        applyStimulus(8'h80, 1'b0, 1'b0, 4);
        applyStimulus(8'h00, 1'b0, 1'b0, 4);
        checkOutput("wrap_delta", 32'(delta), 32'h01);
        checkOutput("wrap_bin", 32'(bin_out), 32'h00);
        applyStimulus(8'h80, 1'b0, 1'b0, 4);
        checkOutput("back_delta", 32'(delta), 32'hFF);
        checkOutput("back_acc", 32'(acc), 32'hFFFF);

        applyStimulus(8'h00, 1'b1, 1'b0, 1);
        applyStimulus(8'h00, 1'b0, 1'b0, 4);
        checkOutput("realign_acc", 32'(acc), 32'd0);
        applyStimulus(8'h02, 1'b0, 1'b0, 4);
        checkOutput("skip_delta", 32'(delta), 32'h03);
        checkOutput("skip_acc", 32'(acc), 32'd3);

        // Clear lands on the very edge at which the new sample reaches s_gc.
        applyStimulus(binToGray(32'h20), 1'b0, 1'b0, SS);
        applyStimulus(binToGray(32'h20), 1'b1, 1'b0, 1);
        checkOutput("clear_no_adv", 32'(adv), 32'd0);
        applyStimulus(binToGray(32'h20), 1'b0, 1'b0, SS);
        checkOutput("clear_still_low", 32'(aligned), 32'd0);
        tick();
        checkOutput("clear_realigned", 32'(aligned), 32'd1);
        checkOutput("clear_acc", 32'(acc), 32'd0);
        checkOutput("clear_bin", 32'(bin_out), 32'h20);

        curBin = 32'h20;
        for (int it = 0; it < 3000; it++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                applyStimulus(gc_in, 1'b0, 1'b1, int'($urandom_range(1, 2)));
            end else if (r < 6) begin
                applyStimulus(gc_in, 1'b1, 1'b0, 1);
            end else begin
                if (r < 50)      curBin = (curBin + 1) % (1 << W);
                else if (r < 80) curBin = (curBin + (1 << W) - 1) % (1 << W);
                else             curBin = int'($urandom_range(0, (1 << W) - 1));
                applyStimulus(binToGray(curBin), 1'b0, 1'b0, int'($urandom_range(1, 4)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
